// File: rtl/ble_cmd_pkg.sv
// Shared types for the BLE command queue: command bytes, FSM states, queue entry.
package ble_cmd_pkg;

  localparam int unsigned GapWDefault = 20;

  // Command bytes understood by the Segway RX path
  typedef enum logic [7:0] {
    CmdG = 8'h47,
    CmdS = 8'h53
  } cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StXmit,
    StGap
  } state_t;

  // Queue entry layout: command in the upper byte, post-transmit gap below it
  typedef struct packed {
    cmd_t                   cmd;
    logic [GapWDefault-1:0] gap;
  } entry_t;

endpackage

// File: rtl/cmd_fifo.sv
// Generic circular buffer with sticky overflow and synchronous flush.
module cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 28
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  input  logic                   flush_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             do_wr, do_rd;

  assign full_o     = (count_q == (PtrW + 1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign rd_data_o  = mem_q[rd_ptr_q];

  // Full is judged on the pre-cycle count, so a same-cycle pop cannot rescue a write
  assign do_wr = wr_en_i && !full_o && !flush_i;
  assign do_rd = rd_en_i && !empty_o && !flush_i;

  // Pointer, count and overflow next-state; flush dominates everything
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (wr_en_i && full_o) overflow_d = 1'b1;
    end
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are only ever read behind a non-empty count
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/ble_cmd_queue.sv
// Scripted BLE-host emulator feeding UART_tx over trmt/tx_data/tx_done.
// Optional keepalive resend of the last byte is enabled by defining CMDQ_KEEPALIVE_EN.
module ble_cmd_queue
  import ble_cmd_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned GAP_W         = GapWDefault,
  parameter int unsigned KEEPALIVE_CYC = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_cmd,
  input  logic [GAP_W-1:0]       wr_gap,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   trmt,
  output logic [7:0]             tx_data,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [15:0]            cmds_sent
);

  localparam int unsigned EntryW = 8 + GAP_W;

  state_t            state_q, state_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [15:0]       cmds_sent_q, cmds_sent_d;
  logic              tx_done_q;
  logic              pop;
  logic              ka_fire;
  logic [EntryW-1:0] fifo_rd_data;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wr_en_i    (wr_en),
    .wr_data_i  ({wr_cmd, wr_gap}),
    .rd_en_i    (pop),
    .rd_data_o  (fifo_rd_data),
    .flush_i    (flush),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .overflow_o (overflow)
  );

`ifdef CMDQ_KEEPALIVE_EN
  localparam int unsigned KaW = $clog2(KEEPALIVE_CYC + 1);

  logic [KaW-1:0] ka_q, ka_d;
  logic           ka_run;

  // Count idle cycles only while nothing is pending and something was sent before
  assign ka_run  = (state_q == StIdle) && empty && (cmds_sent_q != '0) && !wr_en && !flush;
  assign ka_fire = ka_run && (ka_q == KaW'(KEEPALIVE_CYC - 1));

  // Keepalive timer next-state: restarts on any interruption and after firing
  always_comb begin
    ka_d = '0;
    if (ka_run && !ka_fire) ka_d = ka_q + 1'b1;
  end

  // Keepalive timer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ka_q <= '0;
    else        ka_q <= ka_d;
  end
`else
  logic unused_ka_cfg;
  assign unused_ka_cfg = (KEEPALIVE_CYC != 0);
  assign ka_fire       = 1'b0;
`endif

  // Sequencer next-state: pop, strobe, wait for UART completion, then hold the gap
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    gap_d       = gap_q;
    cmds_sent_d = cmds_sent_q;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !flush) begin
          pop       = 1'b1;
          tx_data_d = fifo_rd_data[GAP_W +: 8];
          gap_d     = fifo_rd_data[GAP_W-1:0];
          state_d   = StLoad;
        end else if (ka_fire) begin
          // tx_data_q still holds the last byte sent
          gap_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: state_d = StXmit;
      StXmit: begin
        // The UART cannot be aborted, so flush is ignored until completion
        if (tx_done && !tx_done_q) begin
          cmds_sent_d = cmds_sent_q + 16'd1;
          state_d     = StGap;
        end
      end
      StGap: begin
        if (flush || (gap_q == '0)) state_d = StIdle;
        else                        gap_d   = gap_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer registers and tx_done edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tx_data_q   <= '0;
      gap_q       <= '0;
      cmds_sent_q <= '0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      gap_q       <= gap_d;
      cmds_sent_q <= cmds_sent_d;
      tx_done_q   <= tx_done;
    end
  end

  assign trmt      = (state_q == StLoad);
  assign busy      = (state_q != StIdle);
  assign tx_data   = tx_data_q;
  assign cmds_sent = cmds_sent_q;

endmodule

// File: doc/ble_cmd_queue.md
Name: ble_cmd_queue

Overview:
- Scripted BLE-host emulator that sits directly upstream of the bench-side UART_tx. It feeds the Segway RX command stream.
- Buffers command bytes (e.g. 'G' = 8'h47, 'S' = 8'h53), each tagged with a post-transmit gap in clk cycles.
- Issues them one at a time over the trmt/tx_data/tx_done handshake.
- Replaces hand-coded SendCmd/repeat sequencing in system benches, and is synthesizable for on-board demo stimulus.

Parameters:
- DEPTH, 8, queue entries; power of 2, ≥2.
- GAP_W, 20, width of per-command gap counter.
- KEEPALIVE_CYC, 1_000_000, idle cycles before keepalive resend (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  push {wr_cmd, wr_gap} into queue
- wr_cmd  in  8  command byte
- wr_gap  in  GAP_W  cycles to wait after tx_done before next command
- flush  in  1  discard queued entries, clear overflow
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky: write attempted while full
- trmt  out  1  one-cycle start pulse to UART_tx
- tx_data  out  8  byte to UART_tx
- tx_done  in  1  UART_tx completion, level, cleared by UART_tx on trmt
- busy  out  1  FSM not in IDLE
- cmds_sent  out  16  completed transmissions, wraps 16'hFFFF→0

Behaviour:
- Reset values: all outputs 0, except empty=1. Queue pointers 0. FSM = IDLE.
- Storage: circular buffer, wr_ptr/rd_ptr wrap modulo DEPTH. Entries are {cmd, gap}.
- Write rule: if wr_en && !full && !flush, store and increment count.
- Full write: if wr_en && full (pre-cycle count), drop the data and set overflow. A pop in the same cycle does not rescue the write.
- FSM IDLE: if !empty, pop the head, latch tx_data and gap_cnt, and go to LOAD.
- FSM LOAD: trmt=1 for exactly this cycle, then go to XMIT.
- FSM XMIT: go to GAP on a rising edge of tx_done, using a registered previous tx_done. Increment cmds_sent on that edge.
- FSM GAP: if gap_cnt==0, go to IDLE. Otherwise decrement each cycle. Gap 0 therefore costs exactly 1 cycle in GAP.
- tx_data timing: holds the popped byte from LOAD until the next LOAD.
- Simultaneous pop and write: both happen; count is unchanged.
- Write to empty: the byte can pop the next cycle. Latency wr_en→trmt = 2 cycles when idle.
- Flush effects: clears the queue (pointers and count 0) and clears overflow.
- Flush in GAP: aborts to IDLE.
- Flush in LOAD/XMIT: the in-flight byte completes normally, since the UART cannot be aborted.
- Flush + wr_en in the same cycle: flush wins and the write is dropped.
- busy: 1 in LOAD, XMIT and GAP.
- Reset mid-operation: asynchronous return to the reset values. Any tx in flight is abandoned; the UART_tx shares rst_n.

Optional Feature:
- Macro: CMDQ_KEEPALIVE_EN.
- When defined: a keepalive counter runs while in IDLE with the queue empty and cmds_sent != 0. On reaching KEEPALIVE_CYC it re-transmits the last sent byte with gap 0 via LOAD/XMIT/GAP.
  - The resend counts in cmds_sent.
  - The counter resets on any write, flush, or non-IDLE state.
  - This emulates the BLE app re-asserting 'G'.
- When undefined: no counter; an empty queue idles indefinitely.

Decomposition:
- Shared package ble_cmd_pkg holds:
  - the cmd_t enum (G=8'h47, S=8'h53);
  - the state_t enum {IDLE, LOAD, XMIT, GAP};
  - the entry struct {cmd_t cmd; logic [GAP_W-1:0] gap}.
- One sub-module: cmd_fifo. It is a generic circular buffer, parameterized DEPTH/WIDTH, and owns full/empty/count/overflow.
- The top level holds the FSM, gap counter, cmds_sent and keepalive.

Test Plan:
- Single 'G', gap 0 → trmt high exactly 1 cycle, 2 cycles after wr_en; tx_data=8'h47; after tx_done rises, cmds_sent=1, busy=0 two cycles later.
- Push S(gap 1000), G(gap 0) back-to-back → second trmt exactly 1001+1+1 cycles after first tx_done rise; tx_data sequence 8'h53, 8'h47.
- Hold transmitter busy, write DEPTH+2 entries → full=1, count=8, overflow=1; only first 8 bytes appear on tx_data in order; flush clears overflow.
- Flush asserted during GAP of entry 1 with 3 queued → FSM to IDLE next cycle, empty=1, no further trmt; flush during XMIT → current byte still counted.
- rst_n low mid-XMIT → all outputs at reset values immediately (asynchronous); after release, queue empty, cmds_sent=0, no spurious trmt.
- CMDQ_KEEPALIVE_EN, KEEPALIVE_CYC=5000, send 'G', then idle → trmt with 8'h47 repeats every ~5000+tx cycles; a write resets the timer; undefined build shows no resend.
